lsu_mem_ctrl: RTL

- Parametrised, multi-cycle load/store unit that replaces the single-cycle combinational memory path.
- Accepts one load/store per transaction from the execute stage over a valid/ready handshake.
- Drives a generic request/response memory port with an aligned address, byte strobes and lane-shifted write data.
- Extracts and sign/zero-extends load data, detects misaligned accesses, and returns a result over a valid/ready handshake to writeback.
- One transaction outstanding at a time.

---
 rtl/lsu_mem_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Multi-cycle load/store unit sitting between the execute stage and a generic
// request/response memory port. It accepts one access at a time, issues an
// aligned memory request with byte strobes and lane-shifted write data, waits
// for the response, and returns the extracted and extended load data (or the
// store acknowledge) to writeback.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*                  execute-stage access (valid/ready handshake)
//                          we, size (0=B,1=H,2=W,3=D), signed, addr, wdata
//   mem_req_valid_o/ready  memory request handshake
//   mem_we_o/addr_o/...    aligned address, strobes, lane-shifted store data
//   mem_rsp_valid_i        memory response / write acknowledge
//   mem_rdata_i            full aligned read word
//   mem_rsp_err_i          bus error, qualified by mem_rsp_valid_i
//   rsp_*                  result to writeback (valid/ready handshake)
//                          rdata, misalign flag, bus-error flag
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,

    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_rsp_err_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_misalign_o,
    output logic              rsp_buserr_o
);

    localparam int LANE_W = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Bytes covered by an access of the given size, right-justified.
    function automatic logic [STRB_W-1:0] f_bytes(input logic [1:0] sz);
        logic [STRB_W-1:0] m;
        for (int b = 0; b < STRB_W; b++) begin
            m[b] = (b < (1 << sz));
        end
        return m;
    endfunction

    // A dword access on a 32-bit datapath cannot be expressed on the bus,
    // so it is reported the same way as a misaligned address.
    function automatic logic f_misalign(input logic [2:0] a, input logic [1:0] sz);
        logic mis;
        case (sz)
            2'd0:    mis = 1'b0;
            2'd1:    mis = a[0];
            2'd2:    mis = |a[1:0];
            default: mis = (XLEN == 32) ? 1'b1 : |a[2:0];
        endcase
        return mis;
    endfunction

    // Mask store data to the access width, then move it to its byte lane.
    function automatic logic [XLEN-1:0] f_wdata(input logic [XLEN-1:0] d,
                                                input logic [1:0] sz,
                                                input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] m;
        logic [XLEN-1:0]   r;
        m = f_bytes(sz);
        for (int b = 0; b < STRB_W; b++) begin
            r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : 8'h00;
        end
        return r << {lane, 3'b000};
    endfunction

    // Sign- or zero-extend the low (8 << sz) bits of d to XLEN.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
        logic [XLEN-1:0] r;
        int              nb;
        nb = 8 << sz;
        r  = d;
        if (nb < XLEN) begin
            for (int i = 0; i < XLEN; i++) begin
                if (i >= nb) begin
                    r[i] = sgn & d[nb-1];
                end
            end
        end
        return r;
    endfunction

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [LANE_W-1:0] r_lane;

    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [XLEN-1:0]   r_mem_wdata;

    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_misalign;
    logic              r_rsp_buserr;

    logic [LANE_W-1:0] w_lane;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_aligned;
    logic [XLEN-1:0]   w_rd_shift;

    assign w_lane     = req_addr_i[LANE_W-1:0];
    assign w_misalign = f_misalign(req_addr_i[2:0], req_size_i);
    assign w_aligned  = {req_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign w_rd_shift = mem_rdata_i >> {r_lane, 3'b000};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_size         <= 2'd0;
            r_signed       <= 1'b0;
            r_lane         <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wstrb    <= '0;
            r_mem_wdata    <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_misalign <= 1'b0;
            r_rsp_buserr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we     <= req_we_i;
                        r_size   <= req_size_i;
                        r_signed <= req_signed_i;
                        r_lane   <= w_lane;
                        if (w_misalign) begin
                            // Short-circuit: no memory traffic, straight to result.
                            r_rsp_misalign <= 1'b1;
                            r_rsp_buserr   <= 1'b0;
                            r_rsp_rdata    <= '0;
                            r_state        <= S_RESP;
                        end else begin
                            r_mem_we    <= req_we_i;
                            r_mem_addr  <= w_aligned;
                            r_mem_wstrb <= req_we_i ? (f_bytes(req_size_i) << w_lane) : '1;
                            r_mem_wdata <= f_wdata(req_wdata_i, req_size_i, w_lane);
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Responses are only honoured here, so a late response to
                    // a request aborted by reset is dropped in IDLE.
                    if (mem_rsp_valid_i) begin
                        r_rsp_buserr   <= mem_rsp_err_i;
                        r_rsp_misalign <= 1'b0;
                        r_rsp_rdata    <= (mem_rsp_err_i || r_we) ? '0
                                          : f_extend(w_rd_shift, r_size, r_signed);
                        r_state        <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_ready_i) begin
                        r_rsp_misalign <= 1'b0;
                        r_rsp_buserr   <= 1'b0;
                        r_rsp_rdata    <= '0;
                        r_state        <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign mem_req_valid_o = (r_state == S_REQ);
    assign rsp_valid_o     = (r_state == S_RESP);

    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wstrb_o = r_mem_wstrb;
    assign mem_wdata_o = r_mem_wdata;

    assign rsp_rdata_o    = r_rsp_rdata;
    assign rsp_misalign_o = r_rsp_misalign;
    assign rsp_buserr_o   = r_rsp_buserr;

endmodule
